conv_sequencer: RTL and testbench



---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_seq_cnt.sv | 32 +++
 rtl/conv_sequencer.sv | 136 +++++++++++++
 tb/tb_conv_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sequencer.
// Holds the sequencer state encoding, the output-count function and a
// counter-width helper used to size the sequencer's counters.
package conv_pkg;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CLEAR  = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } seq_state_t;

  // Number of valid-mode outputs produced per frame.
  function automatic int num_y(input int lenx, input int lenf);
    return lenx - lenf + 1;
  endfunction

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_seq_cnt.sv
// Mod-N up-counter with synchronous clear, increment enable and terminal flag.
// Latency: count updates on the clock edge after clr/inc; tc is combinational.
// Backpressure: none; the caller gates inc.
// Ports: clk, reset (sync, active-high), clr, inc -> cnt (0..N-1), tc (cnt == N-1).
module conv_seq_cnt
  import conv_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign tc = (cnt == LAST);

  // Incrementing at the terminal count wraps back to zero.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM for a 1-D valid-mode convolution over a single-port X memory,
// a synchronous filter ROM and a multiply-accumulate datapath.
// Latency: last sample write -> CLEAR next cycle; m_valid_y rises LENF+2 cycles
//   after CLEAR entry; LENF+3 cycles per output when m_ready_y stays high.
// Backpressure: s_ready_x only in LOAD (source stalls otherwise); OUTPUT holds
//   m_valid_y and all addresses frozen until m_ready_y.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   s_valid_x/s_ready_x   sample input handshake; x_wr_en = accepted sample
//   x_addr, f_addr        X memory address (write pointer or read), ROM address
//   clr_acc, en_acc       accumulator clear / accumulate-this-cycle
//   m_valid_y/m_ready_y   result output handshake
//   busy                  high whenever not in LOAD
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int LENX  = 64,
  parameter int LENF  = 33,
  parameter int ADDRX = 6,
  parameter int ADDRF = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic             x_wr_en,
  output logic [ADDRX-1:0] x_addr,
  output logic [ADDRF-1:0] f_addr,
  output logic             clr_acc,
  output logic             en_acc,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             busy
);

  localparam int NUM_Y = num_y(LENX, LENF);

  seq_state_t state, state_nxt;

  logic [ADDRX-1:0] wr_ptr;
  logic [ADDRX-1:0] base;
  logic [ADDRF-1:0] k;
  logic             wr_tc, k_tc, base_tc;
  logic             k_clr, k_inc;
  logic             hs_y;

  // Sample acceptance is suppressed during the reset cycle itself.
  assign s_ready_x = (state == LOAD) && !reset;
  assign x_wr_en   = s_valid_x && s_ready_x;
  assign m_valid_y = (state == OUTPUT);
  assign hs_y      = m_valid_y && m_ready_y;
  assign busy      = (state != LOAD);
  // Holding the accumulator clear in LOAD keeps it zero between frames.
  assign clr_acc   = (state == LOAD) || (state == CLEAR);

  // k restarts for each output. It stops at LENF-1 on the last ISSUE cycle
  // instead of wrapping, so DRAIN and OUTPUT keep the last tap addresses.
  assign k_clr = (state == LOAD) || (state == CLEAR);
  assign k_inc = (state == ISSUE) && !k_tc;

  conv_seq_cnt #(.N(LENX), .W(ADDRX)) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (x_wr_en),
    .cnt   (wr_ptr),
    .tc    (wr_tc)
  );

  conv_seq_cnt #(.N(LENF), .W(ADDRF)) u_tap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (k_clr),
    .inc   (k_inc),
    .cnt   (k),
    .tc    (k_tc)
  );

  conv_seq_cnt #(.N(NUM_Y), .W(ADDRX)) u_base_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (hs_y),
    .cnt   (base),
    .tc    (base_tc)
  );

  // Memory and ROM data arrive one cycle after the address, so accumulate
  // one cycle behind ISSUE: 2nd ISSUE cycle through DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD;
      en_acc <= 1'b0;
    end else begin
      state  <= state_nxt;
      en_acc <= (state == ISSUE);
    end
  end

  always_comb begin
    state_nxt = state;
    x_addr    = base + ADDRX'(k);
    f_addr    = k;
    unique case (state)
      LOAD: begin
        x_addr = wr_ptr;
        f_addr = '0;
        if (x_wr_en && wr_tc) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        x_addr    = base;
        f_addr    = '0;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (k_tc) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (hs_y) begin
          state_nxt = base_tc ? LOAD : CLEAR;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: a small (8/4) and a default (64/33) instance.
// A behavioural harness models the X memory, ROM and accumulator driven by the
// DUT controls, and compares every result against a directly computed convolution.
module tb_conv_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic       rst_s, sv_s, mr_s;
  logic       sr_s, we_s, clr_s, en_s, mv_s, busy_s;
  logic [2:0] xa_s;
  logic [1:0] fa_s;
  // default instance
  logic       rst_d, sv_d, mr_d;
  logic       sr_d, we_d, clr_d, en_d, mv_d, busy_d;
  logic [5:0] xa_d;
  logic [5:0] fa_d;

  conv_sequencer #(.LENX(8), .LENF(4), .ADDRX(3), .ADDRF(2)) u_small (
    .clk(clk), .reset(rst_s), .s_valid_x(sv_s), .s_ready_x(sr_s), .x_wr_en(we_s),
    .x_addr(xa_s), .f_addr(fa_s), .clr_acc(clr_s), .en_acc(en_s),
    .m_valid_y(mv_s), .m_ready_y(mr_s), .busy(busy_s)
  );

  conv_sequencer #(.LENX(64), .LENF(33), .ADDRX(6), .ADDRF(6)) u_dflt (
    .clk(clk), .reset(rst_d), .s_valid_x(sv_d), .s_ready_x(sr_d), .x_wr_en(we_d),
    .x_addr(xa_d), .f_addr(fa_d), .clr_acc(clr_d), .en_acc(en_d),
    .m_valid_y(mv_d), .m_ready_y(mr_d), .busy(busy_d)
  );

  // Per-instance views (index 0 = small, 1 = default)
  logic [1:0] rst_v, sv_v, mr_v, sr_v, we_v, clr_v, en_v, mv_v, busy_v;
  logic [5:0] xa_v [2];
  logic [5:0] fa_v [2];
  assign rst_v  = {rst_d, rst_s};
  assign sv_v   = {sv_d, sv_s};
  assign mr_v   = {mr_d, mr_s};
  assign sr_v   = {sr_d, sr_s};
  assign we_v   = {we_d, we_s};
  assign clr_v  = {clr_d, clr_s};
  assign en_v   = {en_d, en_s};
  assign mv_v   = {mv_d, mv_s};
  assign busy_v = {busy_d, busy_s};
  assign xa_v[0] = {3'b000, xa_s};
  assign xa_v[1] = xa_d;
  assign fa_v[0] = {4'b0000, fa_s};
  assign fa_v[1] = fa_d;

  int xdat [2];
  int lx [2], lf [2], ny [2];
  int mem [2][64];
  int rom [2][64];
  int smp [2][64];
  int expy [2][64];
  int rdx [2], rdf [2], acc [2];
  int wr_cnt [2], out_cnt [2], en_cnt [2], tot_wr [2], tot_out [2], t_clr [2];
  logic mvp [2], holdp [2];
  logic [5:0] hx [2], hf [2];
  int cyc;
  int n_chk, n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of the reference harness, evaluated at the falling edge.
  task automatic model_step();
    int s;
    for (int d = 0; d < 2; d++) begin
      if (rst_v[d]) begin
        check($sformatf("d%0d_ready_during_reset", d), int'(sr_v[d]), 0);
        wr_cnt[d] = 0; out_cnt[d] = 0; en_cnt[d] = 0; acc[d] = 0;
        holdp[d] = 1'b0; mvp[d] = 1'b0; t_clr[d] = -100;
        continue;
      end
      check($sformatf("d%0d_wr_en", d), int'(we_v[d]), int'(sv_v[d] & sr_v[d]));
      check($sformatf("d%0d_ready_vs_busy", d), int'(sr_v[d]), int'(!busy_v[d]));
      if (we_v[d]) begin
        check($sformatf("d%0d_wr_addr", d), int'(xa_v[d]), wr_cnt[d]);
        mem[d][xa_v[d]] = xdat[d];
        smp[d][wr_cnt[d]] = xdat[d];
        wr_cnt[d]++;
        tot_wr[d]++;
        if (wr_cnt[d] == lx[d]) begin
          for (int n = 0; n < ny[d]; n++) begin
            s = 0;
            for (int t = 0; t < lf[d]; t++) s += smp[d][n + t] * rom[d][t];
            expy[d][n] = s;
          end
          wr_cnt[d] = 0;
        end
      end
      if (holdp[d]) begin
        check($sformatf("d%0d_hold_valid", d), int'(mv_v[d]), 1);
        check($sformatf("d%0d_hold_xaddr", d), int'(xa_v[d]), int'(hx[d]));
        check($sformatf("d%0d_hold_faddr", d), int'(fa_v[d]), int'(hf[d]));
        check($sformatf("d%0d_hold_en", d), int'(en_v[d]), 0);
      end
      if (busy_v[d] && clr_v[d]) t_clr[d] = cyc;
      if (mv_v[d] && !mvp[d])
        check($sformatf("d%0d_valid_latency", d), cyc - t_clr[d], lf[d] + 2);
      if (clr_v[d]) acc[d] = 0;
      else if (en_v[d]) acc[d] += rdx[d] * rdf[d];
      if (en_v[d]) en_cnt[d]++;
      if (mv_v[d] && mr_v[d]) begin
        check($sformatf("d%0d_y%0d", d, out_cnt[d]), acc[d], expy[d][out_cnt[d]]);
        check($sformatf("d%0d_en_per_output", d), en_cnt[d], lf[d]);
        en_cnt[d] = 0;
        out_cnt[d]++;
        tot_out[d]++;
        if (out_cnt[d] == ny[d]) out_cnt[d] = 0;
        holdp[d] = 1'b0;
      end else begin
        holdp[d] = mv_v[d];
        hx[d] = xa_v[d];
        hf[d] = fa_v[d];
      end
      rdx[d] = mem[d][xa_v[d]];
      rdf[d] = rom[d][fa_v[d]];
      mvp[d] = mv_v[d];
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        sv;
    logic        mr;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl [16];

  function automatic logic [10:0] mk(input logic sr, input logic we, input logic [2:0] xa,
                                     input logic [1:0] fa, input logic clr, input logic en,
                                     input logic mv, input logic bsy);
    return {sr, we, xa, fa, clr, en, mv, bsy};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] got;
    int rise [8];
    int nr, c, base0;
    logic prev;
    logic [2:0] sx;
    logic [1:0] sf;

    n_chk = 0; n_fail = 0; cyc = 0;
    lx[0] = 8;  lf[0] = 4;  ny[0] = 5;
    lx[1] = 64; lf[1] = 33; ny[1] = 32;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        rom[d][i] = int'($urandom_range(1, 15));
        mem[d][i] = 0;
        smp[d][i] = 0;
        expy[d][i] = 0;
      end
      rdx[d] = 0; rdf[d] = 0; acc[d] = 0; wr_cnt[d] = 0; out_cnt[d] = 0;
      en_cnt[d] = 0; tot_wr[d] = 0; tot_out[d] = 0; t_clr[d] = -100;
      mvp[d] = 1'b0; holdp[d] = 1'b0; hx[d] = '0; hf[d] = '0; xdat[d] = 0;
    end

    // Expected per-cycle outputs for the small instance, first output.
    for (int i = 0; i < 8; i++)
      tbl[i] = {1'b1, 1'b1, mk(1'b1, 1'b1, 3'(i), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[8]  = {1'b1, 1'b1, mk(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1)};
    tbl[9]  = {1'b1, 1'b1, mk(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1)};
    for (int i = 1; i < 4; i++)
      tbl[9 + i] = {1'b1, 1'b1, mk(1'b0, 1'b0, 3'(i), 2'(i), 1'b0, 1'b1, 1'b0, 1'b1)};
    tbl[13] = {1'b1, 1'b1, mk(1'b0, 1'b0, 3'd3, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1)};
    tbl[14] = {1'b1, 1'b1, mk(1'b0, 1'b0, 3'd3, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1)};
    tbl[15] = {1'b1, 1'b1, mk(1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1)};

    // Reset and idle state
    rst_s = 1'b1; rst_d = 1'b1; sv_s = 1'b0; sv_d = 1'b0; mr_s = 1'b0; mr_d = 1'b0;
    step();
    step();
    rst_s = 1'b0; rst_d = 1'b0;
    #1;
    check("reset_s_ready", int'(sr_s), 1);
    check("reset_m_valid", int'(mv_s), 0);
    check("reset_clr_acc", int'(clr_s), 1);
    check("reset_en_acc", int'(en_s), 0);
    check("reset_busy", int'(busy_s), 0);
    check("reset_dflt_ready", int'(sr_d), 1);

    // Table: first frame, samples 1..8, m_ready high
    for (int i = 0; i < 16; i++) begin
      sv_s = tbl[i].sv;
      mr_s = tbl[i].mr;
      xdat[0] = i + 1;
      #1;
      got = {sr_s, we_s, xa_s, fa_s, clr_s, en_s, mv_s, busy_s};
      check($sformatf("vec%0d", i), int'(got), int'(tbl[i].exp));
      step();
    end

    // Rest of frame 1 with m_ready held high: one output every LENF+3 cycles
    sv_s = 1'b0;
    prev = mv_s;
    nr = 0;
    for (c = 0; c < 100 && tot_out[0] < 5; c++) begin
      step();
      if (mv_s && !prev && nr < 8) begin
        rise[nr] = cyc;
        nr++;
      end
      prev = mv_s;
    end
    check("frame1_outputs", tot_out[0], 5);
    check("frame1_rises", nr, 4);
    for (int i = 0; i + 1 < nr; i++)
      check($sformatf("period%0d", i), rise[i + 1] - rise[i], 7);
    check("frame1_done_ready", int'(sr_s), 1);
    check("frame1_done_busy", int'(busy_s), 0);

    // Frame 2: backpressure at output 2
    sv_s = 1'b1; mr_s = 1'b1;
    for (c = 0; c < 40 && tot_wr[0] < 16; c++) begin
      xdat[0] = int'($urandom_range(0, 255));
      step();
    end
    sv_s = 1'b0;
    for (c = 0; c < 100 && tot_out[0] < 7; c++) step();
    mr_s = 1'b0;
    for (c = 0; c < 20 && !mv_s; c++) step();
    check("bp_valid_seen", int'(mv_s), 1);
    sx = xa_s;
    sf = fa_s;
    repeat (10) step();
    check("bp_valid_held", int'(mv_s), 1);
    check("bp_xaddr_frozen", int'(xa_s), int'(sx));
    check("bp_faddr_frozen", int'(fa_s), int'(sf));
    check("bp_en_low", int'(en_s), 0);
    check("bp_no_output", tot_out[0], 7);
    mr_s = 1'b1;
    step();
    check("bp_release_output", tot_out[0], 8);
    check("bp_next_clear", int'(clr_s & busy_s), 1);
    check("bp_next_base", int'(xa_s), 3);
    for (c = 0; c < 100 && tot_out[0] < 10; c++) step();
    check("frame2_outputs", tot_out[0], 10);

    // Frame 3: bubbled input, s_valid toggling every cycle
    sv_s = 1'b0; mr_s = 1'b0;
    for (c = 0; c < 60 && tot_wr[0] < 24; c++) begin
      sv_s = !sv_s;
      xdat[0] = int'($urandom_range(0, 255));
      step();
    end
    check("bubble_writes", tot_wr[0], 24);
    check("bubble_cycles", c, 15);
    sv_s = 1'b0; mr_s = 1'b1;
    for (c = 0; c < 100 && tot_out[0] < 15; c++) step();
    check("frame3_outputs", tot_out[0], 15);

    // Randomized traffic on the small instance, three frames
    for (c = 0; c < 3000 && tot_out[0] < 30; c++) begin
      sv_s = 1'($urandom_range(0, 1));
      mr_s = 1'($urandom_range(0, 1));
      xdat[0] = int'($urandom_range(0, 255));
      step();
    end
    check("random_small_outputs", tot_out[0], 30);
    sv_s = 1'b0; mr_s = 1'b0;

    // Default instance: reset in the middle of ISSUE for output 3
    sv_d = 1'b1; mr_d = 1'b1;
    for (c = 0; c < 200 && tot_wr[1] < 64; c++) begin
      xdat[1] = int'($urandom_range(0, 255));
      step();
    end
    sv_d = 1'b0;
    for (c = 0; c < 400 && tot_out[1] < 3; c++) step();
    check("dflt_first_outputs", tot_out[1], 3);
    repeat (12) step();
    check("dflt_mid_issue_faddr", int'(fa_d), 11);
    check("dflt_mid_issue_en", int'(en_d), 1);
    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    #1;
    check("dflt_rst_ready", int'(sr_d), 1);
    check("dflt_rst_valid", int'(mv_d), 0);
    check("dflt_rst_busy", int'(busy_d), 0);
    check("dflt_rst_clr", int'(clr_d), 1);
    check("dflt_rst_en", int'(en_d), 0);
    check("dflt_rst_wrptr", int'(xa_d), 0);
    base0 = tot_out[1];
    for (c = 0; c < 20000 && tot_out[1] < base0 + 32; c++) begin
      sv_d = 1'($urandom_range(0, 1));
      mr_d = 1'($urandom_range(0, 1));
      xdat[1] = int'($urandom_range(0, 255));
      step();
    end
    check("dflt_full_frame_outputs", tot_out[1] - base0, 32);
    check("dflt_frame_done_ready", int'(sr_d), 1);
    sv_d = 1'b0; mr_d = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
